// File: rtl/ask_demod.sv
// Non-coherent 2ASK demodulator: counts carrier rising edges per bit window
// and recovers start/8-data/stop framed bytes.
module ask_demod #(
  parameter int BIT_CYCLES  = 64,
  parameter int EDGE_THRESH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ask_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int EW = $clog2(BIT_CYCLES + 1);
  localparam logic [EW:0] THRESH = (EW + 1)'(EDGE_THRESH);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          ask_p0, ask_s, ask_d;
  logic          rise;
  logic          win_end;
  logic          bit_val;
  logic [CW-1:0] bit_cnt;
  logic [EW-1:0] edge_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // A rise landing on the last cycle still belongs to the ending window.
  function automatic logic window_bit(input logic [EW-1:0] cnt, input logic r);
    logic [EW:0] total;
    total = {1'b0, cnt} + {{EW{1'b0}}, r};
    return total >= THRESH;
  endfunction

  // Stage p0/s: two-flop synchronizer, then one more flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ask_p0 <= 1'b0;
      ask_s  <= 1'b0;
      ask_d  <= 1'b0;
    end else begin
      ask_p0 <= ask_in;
      ask_s  <= ask_p0;
      ask_d  <= ask_s;
    end
  end

  assign rise    = ask_s & ~ask_d;
  assign win_end = (bit_cnt == LAST_CNT);
  assign bit_val = window_bit(edge_cnt, rise);

  // Frame FSM with window counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      edge_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE) begin
        bit_cnt  <= '0;
        edge_cnt <= '0;
        if (rise) begin
          state    <= START;
          bit_cnt  <= CW'(1);
          edge_cnt <= EW'(1);
          busy     <= 1'b1;
        end
      end else begin
        if (win_end) begin
          bit_cnt  <= '0;
          edge_cnt <= '0;
        end else begin
          bit_cnt  <= bit_cnt + 1'b1;
          edge_cnt <= edge_cnt + EW'(rise);
        end
        case (state)
          START: if (win_end) begin
            if (bit_val) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          DATA: if (win_end) begin
            shreg[bit_idx] <= bit_val;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
          STOP: if (win_end) begin
            if (!bit_val) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ask_demod.sv
// Directed bench for ask_demod: framed clk/4 carrier bursts, table of frames
// plus glitch, mid-frame reset and back-to-back sequences.
module tb_ask_demod;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ask_in = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int dv_cyc [32];
  logic [7:0] dv_data [32];
  int fe_cyc [32];
  int busy_rise_cyc = -1;
  int busy_fall_cyc = -1;
  logic busy_prev = 1'b0;
  logic [7:0] dout_prev = 8'h00;
  int excl_viol = 0;
  int hold_viol = 0;

  ask_demod #(.BIT_CYCLES(64), .EDGE_THRESH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ask_in(ask_in),
    .data_out(data_out), .data_valid(data_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge
  always @(negedge clk) begin
    if (busy && !busy_prev) busy_rise_cyc <= cyc;
    if (!busy && busy_prev) busy_fall_cyc <= cyc;
    if (data_valid) begin
      dv_cyc[dv_cnt % 32]  <= cyc;
      dv_data[dv_cnt % 32] <= data_out;
      dv_cnt <= dv_cnt + 1;
    end
    if (frame_err) begin
      fe_cyc[fe_cnt % 32] <= cyc;
      fe_cnt <= fe_cnt + 1;
    end
    if (data_valid && frame_err) excl_viol <= excl_viol + 1;
    if (rst_n && (data_out != dout_prev) && !data_valid) hold_viol <= hold_viol + 1;
    busy_prev <= busy;
    dout_prev <= data_out;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive n cycles of a bit slot carrying `rises` clk/4 carrier pulses.
  // Caller is aligned to a falling edge; returns aligned to a falling edge.
  task automatic tx_cyc(input int rises, input int n);
    for (int c = 0; c < n; c++) begin
      ask_in = (c < 4 * rises) && ((c % 4) < 2);
      @(negedge clk);
    end
    ask_in = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input int one_r, input int zero_r,
                            input int stop_r, output int r);
    r = cyc + 2;
    tx_cyc(16, 64);
    for (int i = 0; i < 8; i++) tx_cyc(b[i] ? one_r : zero_r, 64);
    tx_cyc(stop_r, 64);
  endtask

  typedef struct {
    logic [7:0] tx;
    int         one_r;
    int         zero_r;
    int         stop_r;
    logic       exp_dv;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int r, r2, dv0, fe0;
    logic [7:0] d_before;

    vecs[0] = '{8'hA5, 16, 0, 0,  1'b1, 8'hA5};
    vecs[1] = '{8'h5A, 16, 0, 0,  1'b1, 8'h5A};
    vecs[2] = '{8'h33, 16, 0, 16, 1'b0, 8'h5A};
    vecs[3] = '{8'h0F, 8,  7, 0,  1'b1, 8'h0F};
    vecs[4] = '{8'hF0, 8,  7, 7,  1'b1, 8'hF0};
    vecs[5] = '{8'h96, 16, 0, 8,  1'b0, 8'hF0};

    repeat (3) @(negedge clk);
    check("reset_data_out", int'(data_out), 0);
    check("reset_valid", int'(data_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    tx_cyc(0, 10);

    for (int v = 0; v < 6; v++) begin
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[v].tx, vecs[v].one_r, vecs[v].zero_r, vecs[v].stop_r, r);
      tx_cyc(0, 40);
      check($sformatf("v%0d_dv_count", v), dv_cnt - dv0, int'(vecs[v].exp_dv));
      check($sformatf("v%0d_fe_count", v), fe_cnt - fe0, int'(!vecs[v].exp_dv));
      check($sformatf("v%0d_data_out", v), int'(data_out), int'(vecs[v].exp_data));
      if (vecs[v].exp_dv) begin
        check($sformatf("v%0d_dv_cycle", v), dv_cyc[dv0 % 32], r + 640);
        check($sformatf("v%0d_dv_data", v), int'(dv_data[dv0 % 32]), int'(vecs[v].exp_data));
      end else begin
        check($sformatf("v%0d_fe_cycle", v), fe_cyc[fe0 % 32], r + 640);
      end
      check($sformatf("v%0d_busy_rise", v), busy_rise_cyc, r + 1);
      check($sformatf("v%0d_busy_fall", v), busy_fall_cyc, r + 640);
    end

    // Single-cycle glitch: false start, no pulses
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    d_before = data_out;
    r = cyc + 2;
    tx_cyc(1, 1);
    tx_cyc(0, 100);
    check("glitch_busy_rise", busy_rise_cyc, r + 1);
    check("glitch_busy_fall", busy_fall_cyc, r + 64);
    check("glitch_dv_count", dv_cnt - dv0, 0);
    check("glitch_fe_count", fe_cnt - fe0, 0);
    check("glitch_data_out", int'(data_out), int'(d_before));

    // Reset asserted during data bit 4
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    tx_cyc(16, 64);
    for (int i = 0; i < 4; i++) tx_cyc(16, 64);
    tx_cyc(16, 30);
    check("midrst_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(data_valid), 0);
    check("midrst_frame_err", int'(frame_err), 0);
    @(negedge clk);
    tx_cyc(0, 3);
    rst_n = 1'b1;
    tx_cyc(0, 100);
    check("midrst_no_dv", dv_cnt - dv0, 0);
    check("midrst_no_fe", fe_cnt - fe0, 0);
    send_frame(8'h3C, 16, 0, 0, r);
    tx_cyc(0, 40);
    check("post_rst_dv_count", dv_cnt - dv0, 1);
    check("post_rst_dv_cycle", dv_cyc[dv0 % 32], r + 640);
    check("post_rst_data", int'(data_out), 8'h3C);

    // Back-to-back frames, one idle bit apart
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h00, 16, 0, 0, r);
    tx_cyc(0, 64);
    send_frame(8'hFF, 16, 0, 0, r2);
    tx_cyc(0, 40);
    check("b2b_start_spacing", r2 - r, 704);
    check("b2b_dv_count", dv_cnt - dv0, 2);
    check("b2b_fe_count", fe_cnt - fe0, 0);
    check("b2b_first_cycle", dv_cyc[dv0 % 32], r + 640);
    check("b2b_gap", dv_cyc[(dv0 + 1) % 32] - dv_cyc[dv0 % 32], 704);
    check("b2b_first_data", int'(dv_data[dv0 % 32]), 8'h00);
    check("b2b_second_data", int'(dv_data[(dv0 + 1) % 32]), 8'hFF);
    check("b2b_data_out", int'(data_out), 8'hFF);

    check("dv_fe_exclusive", excl_viol, 0);
    check("data_out_held", hold_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ask_demod.md
# ask_demod

Non-coherent 2ASK demodulator and frame receiver. It sits directly downstream of the 2ASK modulator. It takes the on/off-keyed carrier (carrier present = 1, absent = 0) and detects carrier energy by counting rising edges per bit window. Framed bytes are recovered and presented to the consumer with a one-cycle valid strobe. Frame format: idle 0, start bit 1, 8 data bits LSB first, stop bit 0.

## Interface
- BIT_CYCLES, 64, clk cycles per bit window (≥ 8).
- EDGE_THRESH, 8, minimum rising edges in a window to decide bit = 1 (1 ≤ EDGE_THRESH ≤ BIT_CYCLES/2).
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ask_in  input  1  2ASK waveform; treated as asynchronous and possibly glitchy.
- data_out  output  8  last correctly received byte.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- frame_err  output  1  one-cycle pulse on a stop-bit violation.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- Input path:
  - 2-flop synchronizer feeds ask_s; ask_d = ask_s delayed by 1 cycle.
  - rise = ask_s & ~ask_d.
- Counters:
  - bit_cnt: width clog2(BIT_CYCLES), runs 0..BIT_CYCLES-1, then wraps to 0.
  - edge_cnt: width clog2(BIT_CYCLES+1), counts rise within the current window. It cannot overflow (max BIT_CYCLES/2).
  - bit_idx: 0..7.
  - shift register: 8 bits.
- Window decision: in the cycle where bit_cnt == BIT_CYCLES-1, bit = ((edge_cnt + rise) ≥ EDGE_THRESH). edge_cnt then restarts at 0 for the next window.
- States:
  - IDLE: on rise, go to START with bit_cnt = 1 and edge_cnt = 1. The rise-detection cycle is cycle 0 of the start window.
  - START: at window end, bit = 1 goes to DATA with bit_idx = 0. bit = 0 is a false start: return to IDLE with no pulses.
  - DATA: at each window end, shift the bit in LSB-first at position bit_idx. After bit_idx 7, go to STOP.
  - STOP: at window end, bit = 0 loads the shift register into data_out, pulses data_valid, and goes to IDLE. bit = 1 pulses frame_err, leaves data_out unchanged, and goes to IDLE.
- Re-arm: IDLE re-arms immediately. If carrier is still present after a frame error, the next rise starts a new START window. This is the intended resynchronization behaviour.
- No timing recovery beyond the start edge. Window alignment comes solely from the start-bit rise.

## Timing
- Reset values:
  - Outputs: data_out = 8'h00, data_valid = 0, frame_err = 0, busy = 0.
  - Internal: state IDLE, all counters and synchronizer flops 0.
- Reset mid-frame takes effect immediately and asynchronously. The partial byte is discarded and no pulse is emitted.
- Input latency: an ask_in rising edge sampled at cycle T produces rise at T+2.
- Frame latency: with rise at cycle R:
  - busy goes high at R+1.
  - data_valid/frame_err are asserted in cycle R+10·BIT_CYCLES, lasting exactly 1 cycle.
  - busy goes low in that same cycle.
- A false start drops busy at R+BIT_CYCLES.
- data_out changes only in the cycle data_valid is high, and is held otherwise.
- data_valid and frame_err are mutually exclusive.
- All outputs are registered.
- A rise in the same cycle as a window end is counted in the ending window, not the next one.

## Test plan
All scenarios use BIT_CYCLES = 64 and EDGE_THRESH = 8. The carrier is clk/4 (16 edges per bit), gated by the frame bits.

- Frame 0xA5 → one data_valid pulse at R+640 with data_out = 0xA5; frame_err never asserted; busy high from R+1 to R+639.
- Frame with stop bit = 1 (carrier), after a prior good byte 0x5A → frame_err pulse at R+640; no data_valid; data_out stays 0x5A.
- Single 1-cycle glitch on ask_in, otherwise idle → START entered; back to IDLE at R+64; no pulses; data_out unchanged.
- rst_n asserted during data bit 4 of a frame → all outputs 0 immediately and busy = 0. After release, a clean 0x3C frame decodes to 0x3C.
- Back-to-back frames 0x00 then 0xFF, separated by one idle bit time → two data_valid pulses 11·64 cycles apart, carrying 0x00 then 0xFF.
- Threshold boundary: data bits carried as bursts of exactly 8 rises → decoded as 1; bursts of 7 rises → decoded as 0. Byte 0x0F built this way decodes to 0x0F.
